// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, ALU opcodes and flag bit positions.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StHold
  } state_e;

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpMul  = 3'd2;
  localparam logic [2:0] OpAnd  = 3'd3;
  localparam logic [2:0] OpOr   = 3'd4;
  localparam logic [2:0] OpNand = 3'd5;
  localparam logic [2:0] OpNor  = 3'd6;
  localparam logic [2:0] OpXor  = 3'd7;

  // Flag vector is ordered {negativo, zero, carry}
  localparam int unsigned FlagCarry = 0;
  localparam int unsigned FlagZero  = 1;
  localparam int unsigned FlagNeg   = 2;

endpackage

// File: rtl/alu_sequencer.sv
// Request/response sequencer for an external ALU: captures operands, drives the ALU for one
// cycle, registers its result and flags, and maintains an accumulator and transaction count.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_WIDTH-1:0]   op_a,
  input  logic signed [DATA_WIDTH-1:0]   op_b,
  input  logic        [2:0]              op_sel,
  input  logic                           acc_mode,
  input  logic                           acc_clr,
  output logic        [DATA_WIDTH-1:0]   port_a,
  output logic        [DATA_WIDTH-1:0]   port_b,
  output logic        [2:0]              selector,
  input  logic        [2*DATA_WIDTH-1:0] alu_out,
  input  logic                           alu_carry,
  input  logic                           alu_zero,
  input  logic                           alu_negativo,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic        [2*DATA_WIDTH-1:0] result,
  output logic        [2:0]              flags,
  output logic        [DATA_WIDTH-1:0]   acc,
  output logic        [7:0]              op_count
);

  state_e state_q;
  logic   accept;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StIdle:  in_ready = 1'b1;
      StHold:  in_ready = res_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign res_valid = (state_q == StHold);

  // The ALU-facing registers double as the captured operands, so they only change on a
  // capture and stay quiet while idle or holding a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      port_a   <= '0;
      port_b   <= '0;
      selector <= OpAdd;
      result   <= '0;
      flags    <= '0;
      acc      <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        port_a   <= acc_mode ? acc : op_a;
        port_b   <= op_b;
        selector <= op_sel;
      end

      if (state_q == StExec) begin
        result           <= alu_out;
        flags[FlagNeg]   <= alu_negativo;
        flags[FlagZero]  <= alu_zero;
        flags[FlagCarry] <= alu_carry;
      end

      if (acc_clr) begin
        acc <= '0;
      end else if (state_q == StExec) begin
        acc <= alu_out[DATA_WIDTH-1:0];
      end

      if (state_q == StHold && res_ready) begin
        op_count <= op_count + 8'd1;
      end

      case (state_q)
        StIdle: if (accept) state_q <= StExec;
        StExec: state_q <= StHold;
        StHold: if (res_ready) state_q <= in_valid ? StExec : StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
